// File: rtl/dl_capture_ctrl.sv
// Byte-command delay-line sampler: full-line or edge-code captures into a shift buffer, read out over a valid/accept byte link.
// Optional capture watchdog is built in when DL_CAPTURE_CTRL_WATCHDOG_EN is defined.
module dl_capture_ctrl #(
    parameter int P_DL_LEN    = 32,
    parameter int P_CHANNELS  = 4,
    parameter int P_BUF_BYTES = 8,
    parameter int P_SAMPLES   = 10,
    parameter int P_TO_W      = 12
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic [7:0]                     i_data,
    output logic                           o_valid,
    input  logic                           i_accept,
    output logic [7:0]                     o_data,
    input  logic                           i_dl_valid,
    input  logic [P_CHANNELS*P_DL_LEN-1:0] i_dl,
    output logic                           o_busy,
    output logic                           o_err
);
    localparam int ENC_W = $clog2(P_DL_LEN);
    localparam int BUF_W = 8 * P_BUF_BYTES;
    localparam int CH_W  = (P_CHANNELS > 1) ? $clog2(P_CHANNELS) : 1;

    localparam logic [3:0] OP_LOAD   = 4'd0;
    localparam logic [3:0] OP_UNLOAD = 4'd1;
    localparam logic [3:0] OP_FULL   = 4'd2;
    localparam logic [3:0] OP_EDGE   = 4'd3;
    localparam logic [3:0] OP_SETN   = 4'd4;
    localparam logic [3:0] OP_ABORT  = 4'd5;
    localparam logic [3:0] OP_STATUS = 4'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_FULL, ST_EDGE} state_t;

    state_t              state_q, state_d;
    logic [BUF_W-1:0]    shift_q, shift_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [4:0]          n_q, n_d;
    logic [4:0]          rem_q, rem_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [3:0]          op, arg;
    logic [P_DL_LEN-1:0] dl_ch [P_CHANNELS];
    logic [P_DL_LEN-1:0] sel_dl;
    logic [ENC_W-1:0]    edge_code;
    logic                to_flag;
    logic                timeout;

    assign op  = i_data[3:0];
    assign arg = i_data[7:4];

    for (genvar gi = 0; gi < P_CHANNELS; gi++) begin : g_ch
        assign dl_ch[gi] = i_dl[gi*P_DL_LEN +: P_DL_LEN];
    end

    assign sel_dl = dl_ch[ch_q];

    // Highest 1->0 transition (walking upward) wins; code 0 means no edge found.
    always_comb begin
        edge_code = '0;
        for (int k = 0; k < P_DL_LEN - 1; k++) begin
            if (sel_dl[k] && !sel_dl[k+1]) begin
                edge_code = ENC_W'(k + 1);
            end
        end
    end

`ifdef DL_CAPTURE_CTRL_WATCHDOG_EN
    localparam logic [P_TO_W-1:0] WD_LAST = ~P_TO_W'(1);

    logic [P_TO_W-1:0] wd_q, wd_d;
    logic              to_flag_q, to_flag_d;
    logic              to_clr;

    // Counter restarts whenever idle or on a strobe, so each capture gets a full window.
    always_comb begin
        wd_d    = '0;
        timeout = 1'b0;
        if (busy_q && !i_dl_valid) begin
            wd_d    = wd_q + P_TO_W'(1);
            timeout = (wd_q == WD_LAST);
        end
        to_clr    = i_valid && !busy_q && (op == OP_STATUS);
        to_flag_d = to_clr ? 1'b0 : (to_flag_q | timeout);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q      <= '0;
            to_flag_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign to_flag = to_flag_q;
`else
    assign to_flag = 1'b0;
    assign timeout = 1'b0;
`endif

    // Order within a cycle: readout shift, then capture shift, then command.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        valid_d = valid_q;
        err_d   = err_q;
        n_d     = n_q;
        rem_d   = rem_q;
        ch_d    = ch_q;

        if (valid_q && i_accept) begin
            shift_d = BUF_W'({shift_d, 8'h00});
            valid_d = 1'b0;
        end

        if (state_q == ST_FULL && i_dl_valid) begin
            shift_d = BUF_W'({shift_d, sel_dl});
            state_d = ST_IDLE;
        end else if (state_q == ST_EDGE && i_dl_valid) begin
            shift_d = BUF_W'({shift_d, edge_code});
            rem_d   = rem_q - 5'd1;
            if (rem_q == 5'd1) begin
                state_d = ST_IDLE;
            end
        end

        if (timeout) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
        end

        if (i_valid) begin
            if (busy_q && op != OP_UNLOAD && op != OP_ABORT) begin
                err_d = 1'b1;
            end else begin
                case (op)
                    OP_LOAD:   shift_d = BUF_W'({shift_d, arg});
                    OP_UNLOAD: valid_d = 1'b1;
                    OP_FULL, OP_EDGE: begin
                        if ({28'd0, arg} >= 32'(P_CHANNELS)) begin
                            err_d = 1'b1;
                        end else begin
                            ch_d    = arg[CH_W-1:0];
                            rem_d   = n_q;
                            state_d = (op == OP_FULL) ? ST_FULL : ST_EDGE;
                        end
                    end
                    OP_SETN:   n_d = {1'b0, arg} + 5'd1;
                    OP_ABORT:  state_d = ST_IDLE;
                    OP_STATUS: begin
                        shift_d = BUF_W'({shift_d, 4'b0000, to_flag, err_q, busy_q, valid_q});
                        err_d   = 1'b0;
                    end
                    default:   err_d = 1'b1;
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= 5'(P_SAMPLES);
            rem_q   <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            ch_q    <= ch_d;
        end
    end

    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;
    assign o_data  = shift_q[BUF_W-1 -: 8];

endmodule

// File: tb/tb_dl_capture_ctrl.sv
// Scoreboard bench for dl_capture_ctrl: a bit-queue model predicts every byte and status flag.
module tb_dl_capture_ctrl;
    localparam int DL    = 32;
    localparam int CH    = 4;
    localparam int BUF_W = 64;
    localparam int NS    = 10;
    localparam int TO_W  = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_valid, i_accept, i_dl_valid;
    logic [7:0]      i_data;
    logic [CH*DL-1:0] i_dl;
    logic            o_valid, o_busy, o_err;
    logic [7:0]      o_data;

    int errors = 0;
    int checks = 0;

    bit         mbuf[$];
    logic [7:0] sb_q[$];
    logic [7:0] mon_exp;
    bit         m_valid, m_err, m_to;
    int         m_mode, m_ch, m_rem, m_n;

    always #5 clk = ~clk;

    dl_capture_ctrl #(
        .P_DL_LEN(DL), .P_CHANNELS(CH), .P_BUF_BYTES(8), .P_SAMPLES(NS), .P_TO_W(TO_W)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .i_accept(i_accept), .o_data(o_data),
        .i_dl_valid(i_dl_valid), .i_dl(i_dl), .o_busy(o_busy), .o_err(o_err)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic void m_reset();
        mbuf.delete();
        for (int i = 0; i < BUF_W; i++) mbuf.push_back(1'b0);
        m_valid = 0; m_err = 0; m_to = 0; m_mode = 0; m_ch = 0; m_rem = 0; m_n = NS;
    endfunction

    // mbuf[0] is the oldest (most significant) bit; new bits join at the back.
    function automatic void m_insert(input logic [63:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) mbuf.push_back(v[i]);
        while (mbuf.size() > BUF_W) void'(mbuf.pop_front());
    endfunction

    function automatic logic [7:0] m_top();
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mbuf[i]};
        return b;
    endfunction

    function automatic int edge_model(input logic [DL-1:0] d);
        for (int k = DL - 2; k >= 0; k--) begin
            if (d[k] && !d[k+1]) return k + 1;
        end
        return 0;
    endfunction

    task automatic cycle(input bit v, input logic [3:0] op, input logic [3:0] arg, input bit acc, input bit stb);
        bit pv, pe, pb;
        pv = m_valid; pe = m_err; pb = (m_mode != 0);
        i_valid = v; i_data = {arg, op}; i_accept = acc; i_dl_valid = stb;
        if (acc && m_valid) begin
            sb_q.push_back(m_top());
            m_insert(64'h0, 8);
            m_valid = 0;
        end
        if (stb && m_mode == 1) begin
            m_insert(64'(i_dl[m_ch*DL +: DL]), DL);
            m_mode = 0;
        end else if (stb && m_mode == 2) begin
            m_insert(64'(edge_model(i_dl[m_ch*DL +: DL])), 5);
            m_rem--;
            if (m_rem == 0) m_mode = 0;
        end
        if (v) begin
            if (pb && op != 4'd1 && op != 4'd5) m_err = 1;
            else begin
                case (op)
                    4'd0: m_insert(64'(arg), 4);
                    4'd1: m_valid = 1;
                    4'd2, 4'd3: begin
                        if (int'(arg) >= CH) m_err = 1;
                        else begin
                            m_ch = int'(arg); m_rem = m_n; m_mode = (op == 4'd2) ? 1 : 2;
                        end
                    end
                    4'd4: m_n = int'(arg) + 1;
                    4'd5: m_mode = 0;
                    4'd6: begin
                        m_insert(64'({4'b0000, m_to, pe, pb, pv}), 8);
                        m_err = 0; m_to = 0;
                    end
                    default: m_err = 1;
                endcase
            end
        end
        @(posedge clk); #1;
        i_valid = 0; i_accept = 0; i_dl_valid = 0;
        check("busy", 32'(o_busy), 32'(m_mode != 0));
        check("err", 32'(o_err), 32'(m_err));
        check("valid", 32'(o_valid), 32'(m_valid));
        check("data", 32'(o_data), 32'(m_top()));
    endtask

    task automatic cmd(input logic [3:0] op, input logic [3:0] arg);
        cycle(1'b1, op, arg, 1'b0, 1'b0);
    endtask

    task automatic strobe();
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cycle(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic unload();
        cmd(4'd1, 4'd0);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic rand_dl();
        for (int c = 0; c < CH; c++) i_dl[c*DL +: DL] = $urandom;
    endtask

    task automatic set_ch(input int c, input logic [DL-1:0] val);
        rand_dl();
        i_dl[c*DL +: DL] = val;
    endtask

    task automatic do_reset();
        rst = 1; i_valid = 0; i_accept = 0; i_dl_valid = 0; i_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_reset();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
    endtask

    // Monitor: every accepted byte is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!rst && o_valid && i_accept) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL tx_byte: got %02h with no byte expected", o_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (o_data !== mon_exp) begin
                    errors++;
                    $display("FAIL tx_byte: got %02h expected %02h", o_data, mon_exp);
                end else begin
                    $display("tx byte %02h", o_data);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1; i_dl = '0;
        do_reset();

        // Full capture; the strobe in the command cycle must be ignored.
        set_ch(1, 32'hDEADBEEF);
        cycle(1'b1, 4'd2, 4'd1, 1'b0, 1'b1);
        idle(); idle();
        strobe();
        for (int i = 0; i < 8; i++) unload();

        // Edge capture with default N.
        set_ch(0, 32'h0000_00FF);
        cmd(4'd3, 4'd0);
        repeat (10) strobe();
        for (int i = 0; i < 8; i++) unload();

        // SETN 4, zero-code captures, rejected FULL while busy.
        cmd(4'd4, 4'd3);
        set_ch(2, 32'h0);
        cmd(4'd3, 4'd2);
        strobe(); strobe();
        cmd(4'd2, 4'd1);
        strobe(); strobe();
        idle();
        cmd(4'd6, 4'd0);
        unload();

        // Bad channel, then STATUS read-out clears the error.
        cmd(4'd2, 4'd5);
        cmd(4'd6, 4'd0);
        unload();

        // Hold o_valid without accept.
        cmd(4'd0, 4'hA); cmd(4'd0, 4'h5);
        cmd(4'd1, 4'd0);
        repeat (20) idle();
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

        // Accept and capture shift in the same cycle.
        set_ch(3, $urandom);
        cmd(4'd3, 4'd3);
        cmd(4'd1, 4'd0);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
        repeat (3) strobe();
        unload();

        // UNLOAD together with accept keeps o_valid high.
        cmd(4'd1, 4'd0);
        cycle(1'b1, 4'd1, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

        // Unlisted opcode.
        cmd(4'd9, 4'd0);
        cmd(4'd6, 4'd0);
        unload();

        // Reset mid-capture.
        cmd(4'd3, 4'd1);
        strobe();
        do_reset();

        for (int it = 0; it < 60; it++) begin
            rand_dl();
            case ($urandom_range(0, 6))
                0: cmd(4'd0, 4'($urandom_range(0, 15)));
                1: cmd(4'd4, 4'($urandom_range(0, 5)));
                2: begin
                    cmd(4'd2, 4'($urandom_range(0, 5)));
                    repeat ($urandom_range(0, 2)) idle();
                    strobe();
                end
                3: begin
                    cmd(4'd3, 4'($urandom_range(0, 3)));
                    for (int s = 0; s < 40 && m_mode != 0; s++) begin
                        rand_dl();
                        cycle(1'($urandom_range(0, 3) == 0), 4'd1, 4'd0,
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    end
                    if (m_mode != 0) cmd(4'd5, 4'd0);
                end
                4: unload();
                5: cmd(4'd6, 4'd0);
                default: cycle(1'b0, 4'd0, 4'd0, 1'($urandom_range(0, 1)), 1'b1);
            endcase
        end
        if (m_valid) cycle(1'b0, 4'd0, 4'd0, 1'b1, 1'b0);

`ifdef DL_CAPTURE_CTRL_WATCHDOG_EN
        begin
            int bc;
            cmd(4'd6, 4'd0);
            cmd(4'd3, 4'd0);
            bc = 0;
            while (o_busy && bc < 10000) begin
                bc++;
                @(posedge clk); #1;
            end
            check("wd_busy_cycles", 32'(bc), 32'((1 << TO_W) - 1));
            m_mode = 0; m_err = 1; m_to = 1;
            check("wd_err", 32'(o_err), 32'd1);
            cmd(4'd6, 4'd0);
            unload();
        end
`else
        cmd(4'd3, 4'd0);
        repeat (100) idle();
        cmd(4'd5, 4'd0);
`endif

        idle();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
